srio_nwr_scheduler: RTL and testbench

SRIO_NWR_SCHEDULER -- requirements
Module: srio_nwr_scheduler

---
 rtl/srio_nwr_pkg.sv | 14 +
 rtl/srio_rr_arbiter.sv | 24 ++
 rtl/srio_nwr_scheduler.sv | 151 +++++++++++++++
 tb/tb_srio_nwr_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/srio_nwr_pkg.sv
// srio_nwr_pkg: shared types, widths and helpers for the SRIO NWRITE scheduler
package srio_nwr_pkg;
    localparam int NUM_REQ    = 2;
    localparam int DATA_W     = 64;
    localparam int KEEP_W     = 8;
    localparam int LEN_W      = 16;
    localparam int ADDR_W_DEF = 34;

    typedef enum logic [1:0] {IDLE, REQ, XFER, WAIT_DONE} state_t;

    function automatic logic [LEN_W-1:0] round8(input logic [LEN_W-1:0] len);
        return (len + LEN_W'(7)) & ~LEN_W'(7);
    endfunction
endpackage

// File: rtl/srio_rr_arbiter.sv
// srio_rr_arbiter: two-requester round-robin grant; ptr_q names the requester with priority
module srio_rr_arbiter
    import srio_nwr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    input  logic               served,
    output logic [NUM_REQ-1:0] gnt
);
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = update ? ~served : ptr_q;
        gnt   = req[ptr_q]  ? (ptr_q ? 2'b10 : 2'b01) :
                req[~ptr_q] ? (ptr_q ? 2'b01 : 2'b10) : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/srio_nwr_scheduler.sv
// srio_nwr_scheduler: arbitrates two packet sources onto one SRIO NWRITE user port.
// Optional done-timeout recovery under `SRIO_NWR_DONE_TIMEOUT_EN.
module srio_nwr_scheduler
    import srio_nwr_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WIN_BYTES   = 65536,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk_srio,
    input  logic                  reset_srio,
    input  logic [1:0]            req_in,
    input  logic [127:0]          req_tdata_in,
    input  logic [15:0]           req_tkeep_in,
    input  logic [31:0]           req_tlen_in,
    input  logic [1:0]            req_tvalid_in,
    input  logic [1:0]            req_tfirst_in,
    input  logic [1:0]            req_tlast_in,
    output logic [1:0]            req_tready_out,
    input  logic [2*ADDR_W-1:0]   base_addr_in,
    output logic [1:0]            grant_out,
    output logic                  busy_out,
    output logic                  nwr_req_out,
    input  logic                  nwr_ready_in,
    input  logic                  nwr_done_in,
    output logic [ADDR_W-1:0]     user_taddr_out,
    output logic [15:0]           user_tlen_out,
    output logic [63:0]           user_tdata_out,
    output logic [7:0]            user_tkeep_out,
    output logic                  user_tvalid_out,
    output logic                  user_tfirst_out,
    output logic                  user_tlast_out,
    input  logic                  user_tready_in,
    output logic                  timeout_err_out
);
    localparam logic [ADDR_W:0] WIN     = (ADDR_W+1)'(WIN_BYTES);
    localparam logic [ADDR_W:0] MAX_PKT = (ADDR_W+1)'(256);

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d, gnt;
    logic [ADDR_W-1:0]   taddr_q, taddr_d, nxt_off;
    logic [ADDR_W-1:0]   off_q [NUM_REQ];
    logic [ADDR_W-1:0]   off_d [NUM_REQ];
    logic [LEN_W-1:0]    tlen_q, tlen_d;
    logic [ADDR_W:0]     nxt_end;
    logic                g, win, xfer, beat_last, arb_upd;

    srio_rr_arbiter u_arb (
        .clk    (clk_srio),
        .rst    (reset_srio),
        .req    (req_in),
        .update (arb_upd),
        .served (g),
        .gnt    (gnt)
    );

    assign g         = grant_q[1];
    assign win       = gnt[1];
    assign xfer      = state_q == XFER;
    assign beat_last = xfer & req_tvalid_in[g] & user_tready_in & req_tlast_in[g];
    assign nxt_off   = off_q[g] + ADDR_W'(round8(tlen_q));
    assign nxt_end   = {1'b0, nxt_off} + MAX_PKT;

    assign grant_out      = grant_q;
    assign busy_out       = state_q != IDLE;
    assign nwr_req_out    = state_q == REQ;
    assign user_taddr_out = taddr_q;
    assign user_tlen_out  = tlen_q;

    always_comb begin
        user_tdata_out  = xfer ? (g ? req_tdata_in[127:64] : req_tdata_in[63:0]) : '0;
        user_tkeep_out  = xfer ? (g ? req_tkeep_in[15:8] : req_tkeep_in[7:0]) : '0;
        user_tvalid_out = xfer & req_tvalid_in[g];
        user_tfirst_out = xfer & req_tfirst_in[g];
        user_tlast_out  = xfer & req_tlast_in[g];
        req_tready_out  = xfer ? (g ? {user_tready_in, 1'b0} : {1'b0, user_tready_in}) : 2'b00;
    end

`ifdef SRIO_NWR_DONE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    assign timeout_err_out = tmo_q;
`else
    assign timeout_err_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        taddr_d = taddr_q;
        tlen_d  = tlen_q;
        off_d   = off_q;
        arb_upd = 1'b0;
`ifdef SRIO_NWR_DONE_TIMEOUT_EN
        tmo_d   = 1'b0;
        cnt_d   = state_q == WAIT_DONE ? cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            IDLE: if (|req_in) begin
                grant_d = gnt;
                tlen_d  = win ? req_tlen_in[31:16] : req_tlen_in[15:0];
                taddr_d = (win ? base_addr_in[2*ADDR_W-1:ADDR_W] : base_addr_in[ADDR_W-1:0]) + off_q[win];
                state_d = REQ;
            end
            REQ:  if (nwr_ready_in) state_d = XFER;
            XFER: if (beat_last) state_d = WAIT_DONE;
            default: begin
                if (nwr_done_in) begin
                    off_d[g] = nxt_end > WIN ? '0 : nxt_off;
                    arb_upd  = 1'b1;
                    grant_d  = '0;
                    state_d  = IDLE;
                end
`ifdef SRIO_NWR_DONE_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    arb_upd = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk_srio or posedge reset_srio) begin
        if (reset_srio) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            taddr_q  <= '0;
            tlen_q   <= '0;
            off_q[0] <= '0;
            off_q[1] <= '0;
`ifdef SRIO_NWR_DONE_TIMEOUT_EN
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            taddr_q  <= taddr_d;
            tlen_q   <= tlen_d;
            off_q    <= off_d;
`ifdef SRIO_NWR_DONE_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_srio_nwr_scheduler.sv
// tb_srio_nwr_scheduler: directed self-checking bench, 512-byte windows, 16-cycle done timeout
module tb_srio_nwr_scheduler;
    logic         clk_srio = 1'b0;
    logic         reset_srio;
    logic [1:0]   req_in, req_tvalid_in, req_tfirst_in, req_tlast_in, req_tready_out, grant_out;
    logic [127:0] req_tdata_in;
    logic [15:0]  req_tkeep_in;
    logic [31:0]  req_tlen_in;
    logic [67:0]  base_addr_in;
    logic         busy_out, nwr_req_out, nwr_ready_in, nwr_done_in;
    logic [33:0]  user_taddr_out;
    logic [15:0]  user_tlen_out;
    logic [63:0]  user_tdata_out;
    logic [7:0]   user_tkeep_out;
    logic         user_tvalid_out, user_tfirst_out, user_tlast_out, user_tready_in, timeout_err_out;
    int           n_assert = 0;
    int           n_fail = 0;

    always #5 clk_srio = ~clk_srio;

    srio_nwr_scheduler #(.ADDR_W(34), .WIN_BYTES(512), .TIMEOUT_CYC(16)) dut (
        .clk_srio(clk_srio), .reset_srio(reset_srio), .req_in(req_in),
        .req_tdata_in(req_tdata_in), .req_tkeep_in(req_tkeep_in), .req_tlen_in(req_tlen_in),
        .req_tvalid_in(req_tvalid_in), .req_tfirst_in(req_tfirst_in), .req_tlast_in(req_tlast_in),
        .req_tready_out(req_tready_out), .base_addr_in(base_addr_in), .grant_out(grant_out),
        .busy_out(busy_out), .nwr_req_out(nwr_req_out), .nwr_ready_in(nwr_ready_in),
        .nwr_done_in(nwr_done_in), .user_taddr_out(user_taddr_out), .user_tlen_out(user_tlen_out),
        .user_tdata_out(user_tdata_out), .user_tkeep_out(user_tkeep_out),
        .user_tvalid_out(user_tvalid_out), .user_tfirst_out(user_tfirst_out),
        .user_tlast_out(user_tlast_out), .user_tready_in(user_tready_in),
        .timeout_err_out(timeout_err_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_srio);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, grant_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_nwr_req"}, nwr_req_out, 0);
        chk({tag, "_taddr"}, user_taddr_out, 0);
        chk({tag, "_tlen"}, user_tlen_out, 0);
        chk({tag, "_tdata"}, user_tdata_out, 0);
        chk({tag, "_tvalid"}, {user_tvalid_out, user_tfirst_out, user_tlast_out}, 0);
        chk({tag, "_tready"}, req_tready_out, 0);
        chk({tag, "_tmo"}, timeout_err_out, 0);
    endtask

    task automatic start_pkt(input logic [1:0] req, input int r, input int len,
                             input logic [33:0] addr, input bit hold);
        req_in = req;
        req_tlen_in = {16'(len), 16'(len)};
        tick;
        req_in = hold ? req : 2'b00;
        chk("grant", grant_out, r ? 2'b10 : 2'b01);
        chk("taddr", user_taddr_out, addr);
        chk("tlen", user_tlen_out, 64'(len));
        chk("nwr_req", nwr_req_out, 1);
        chk("busy", busy_out, 1);
        nwr_done_in = 1'b1;
        tick;
        nwr_done_in = 1'b0;
        chk("done_ignored", nwr_req_out, 1);
        nwr_ready_in = 1'b1;
        tick;
        nwr_ready_in = 1'b0;
        chk("nwr_req_drop", nwr_req_out, 0);
    endtask

    task automatic xfer(input int r, input int len, input bit tgl);
        int nb = (len + 7) / 8;
        int k = 0;
        int cyc = 0;
        logic [63:0] d0, d1;
        req_tvalid_in = 2'b11;
        while (k < nb && cyc < 80) begin
            user_tready_in = tgl ? cyc[0] : 1'b1;
            d0 = 64'hA000_0000_0000_0000 | 64'(k);
            d1 = 64'hB000_0000_0000_0000 | 64'(k);
            req_tdata_in = {d1, d0};
            req_tkeep_in = 16'hF00F;
            req_tfirst_in = {2{k == 0}};
            req_tlast_in = {2{k == nb - 1}};
            #1;
            chk("tdata", user_tdata_out, r ? d1 : d0);
            chk("tkeep", user_tkeep_out, r ? 8'hF0 : 8'h0F);
            chk("tvalid", user_tvalid_out, 1);
            chk("tfirst", user_tfirst_out, 64'(k == 0));
            chk("tlast", user_tlast_out, 64'(k == nb - 1));
            chk("tready", req_tready_out, user_tready_in ? (r ? 2'b10 : 2'b01) : 2'b00);
            tick;
            if (user_tready_in) k++;
            cyc++;
        end
        chk("xfer_bound", 64'(cyc < 80), 1);
        req_tvalid_in = 2'b00;
        req_tfirst_in = 2'b00;
        req_tlast_in = 2'b00;
        user_tready_in = 1'b0;
        #1;
        chk("wait_no_valid", user_tvalid_out, 0);
        chk("wait_busy", busy_out, 1);
        chk("wait_grant", grant_out, r ? 2'b10 : 2'b01);
    endtask

    task automatic done_pkt;
        nwr_done_in = 1'b1;
        tick;
        nwr_done_in = 1'b0;
        chk("idle_busy", busy_out, 0);
        chk("grant_clr", grant_out, 0);
    endtask

    task automatic pkt(input logic [1:0] req, input int r, input int len,
                       input logic [33:0] addr, input bit hold, input bit tgl);
        start_pkt(req, r, len, addr, hold);
        xfer(r, len, tgl);
        done_pkt();
    endtask

    initial begin
        reset_srio = 1'b1;
        req_in = 0; req_tdata_in = 0; req_tkeep_in = 0; req_tlen_in = 0;
        req_tvalid_in = 0; req_tfirst_in = 0; req_tlast_in = 0;
        nwr_ready_in = 0; nwr_done_in = 0; user_tready_in = 0;
        base_addr_in = {34'h2000, 34'h1000};
        tick;
        tick;
        reset_srio = 1'b0;
        chk_all_zero("reset");

        pkt(2'b11, 0, 64, 34'h1000, 1, 0);
        pkt(2'b11, 1, 24, 34'h2000, 1, 0);
        pkt(2'b11, 0, 8,  34'h1040, 1, 0);
        pkt(2'b11, 1, 5,  34'h2018, 1, 0);
        pkt(2'b01, 0, 24, 34'h1048, 0, 1);

        start_pkt(2'b01, 0, 64, 34'h1060, 0);
        req_tvalid_in = 2'b11;
        user_tready_in = 1'b1;
        tick;
        tick;
        chk("pre_reset_valid", user_tvalid_out, 1);
        #1 reset_srio = 1'b1;
        #1 chk_all_zero("midpkt_reset");
        tick;
        reset_srio = 1'b0;
        req_tvalid_in = 2'b00;
        user_tready_in = 1'b0;

        pkt(2'b11, 0, 256, 34'h1000, 0, 0);
        pkt(2'b01, 0, 256, 34'h1100, 0, 0);
        pkt(2'b01, 0, 256, 34'h1000, 0, 0);
        pkt(2'b01, 0, 256, 34'h1100, 0, 0);
        pkt(2'b10, 1, 256, 34'h2000, 0, 0);
        pkt(2'b10, 1, 8,   34'h2100, 0, 0);
        pkt(2'b10, 1, 8,   34'h2000, 0, 0);

`ifdef SRIO_NWR_DONE_TIMEOUT_EN
        start_pkt(2'b01, 0, 8, 34'h1000, 0);
        xfer(0, 8, 0);
        for (int i = 0; i < 15; i++) begin
            tick;
            chk("tmo_quiet", {busy_out, timeout_err_out}, 2'b10);
        end
        tick;
        chk("tmo_pulse", {busy_out, timeout_err_out, grant_out}, 4'b0100);
        tick;
        chk("tmo_single", timeout_err_out, 0);
        pkt(2'b11, 1, 8, 34'h2008, 0, 0);
        pkt(2'b01, 0, 8, 34'h1000, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
